prng_stream: RTL
================

Name: prng_stream

Overview:
- Parametrised successor to the wallet's fixed 32-bit/8-bit `random` generator.
- Xorshift PRNG with configurable state and output widths and a runtime seed-load strobe.
- Zero-seed guard, plus a burst engine that emits a requested number of words over a valid/ready stream.
- Feeds key/nonce generation logic that consumes pseudo-random bytes on demand.

Parameters:
STATE_W, 32, PRNG state width; legal values 32 (xorshift32, shifts 13/17/5) or 64 (xorshift64, shifts 13/7/17); any other value is a synthesis error
OUT_W, 8, output word width; 1..STATE_W; o_data = state[OUT_W-1:0]
LEN_W, 16, width of burst length field
DEFAULT_SEED, 32'h2545F491, reset/zero-substitute seed; STATE_W bits wide, must be nonzero

Ports:
i_clk  input  1  system clock, all logic rising-edge
i_reset_n  input  1  asynchronous active-low reset
i_seed  input  STATE_W  seed value
i_seed_load  input  1  load i_seed into state (IDLE only)
i_req  input  1  start a burst (IDLE only), single-cycle strobe
i_req_len  input  LEN_W  number of words in burst, sampled with i_req
i_ready  input  1  consumer accepts o_data this cycle
o_data  output  OUT_W  current word, low bits of state
o_valid  output  1  o_data valid
o_busy  output  1  burst in progress (RUN or DONE)
o_done  output  1  one-cycle pulse at burst end

Behaviour:
- Reset (async assert, sync release):
  - state=DEFAULT_SEED, FSM=IDLE, count=0.
  - o_valid=0, o_busy=0, o_done=0.
  - o_data=DEFAULT_SEED[OUT_W-1:0].
- Step function:
  - STATE_W=32: x^=x<<13; x^=x>>17; x^=x<<5.
  - STATE_W=64: x^=x<<13; x^=x>>7; x^=x<<17.
  - All shifts are logical, truncated to STATE_W, and computed combinationally in one cycle.
- Seed load:
  - In IDLE, i_seed_load=1 sets state<=i_seed next edge.
  - If i_seed==0, state<=DEFAULT_SEED instead, so the state is never zero.
  - Ignored in RUN/DONE.
- FSM IDLE:
  - i_req=1 with i_req_len!=0: count<=i_req_len, go to RUN; o_valid=1 from the next cycle (1-cycle latency).
  - i_req=1 with i_req_len==0: go to DONE, no data emitted.
- Simultaneous i_seed_load and i_req in IDLE: both take effect; the first burst word is the low bits of the newly loaded (or substituted) seed.
- FSM RUN:
  - o_valid=1.
  - Transfer occurs on o_valid&&i_ready: state<=step(state), count<=count-1.
  - Transfer with count==1: go to DONE, o_valid=0 next cycle.
  - Without a transfer, o_data, state and count hold (stream stability rule).
  - i_req and i_seed_load are ignored.
- FSM DONE: o_done=1 for exactly one cycle, o_valid=0, then IDLE.
- o_busy=1 in RUN and DONE.
- Outside RUN the state does not advance; it persists across bursts, so consecutive bursts continue the same sequence.
- Reset mid-burst: immediate return to reset values; o_valid drops asynchronously; no o_done.
- Max burst is 2^LEN_W-1 words; count never wraps.

Test Plan:
- Reset released, i_req=1, i_req_len=2, i_ready=1 → o_valid high next cycle; words 0x91 then step(0x2545F491)[7:0]; o_done pulses one cycle after the 2nd transfer; o_busy low afterwards.
- IDLE i_seed=1, i_seed_load=1, then i_req len 3 with i_ready=1 → o_data 0x01, 0x21 (step(1)=0x00042021), then low byte of step(0x00042021) as computed by the reference model.
- i_seed=0 load → state reads DEFAULT_SEED; first word is 0x91; o_data never stuck at 0 over 1000 words.
- i_ready toggled 1,0,0,1 during a len=4 burst → o_data holds during stalls; exactly 4 transfers match model order; o_done pulse after the 4th.
- i_req_len=0 → no o_valid; o_done high one cycle after i_req; i_req and i_seed_load pulsed during RUN have no effect on count or sequence.
- i_reset_n dropped mid-burst of len 10 after 3 words → o_valid/o_busy go 0 immediately, no o_done; state=DEFAULT_SEED after release. Repeat with STATE_W=64, OUT_W=16 against the model.

Source files
------------

// File: rtl/prng_stream_if.sv
// Stream/control bundle for prng_stream: seed and burst-request inputs plus the
// valid/ready word stream and burst status back to the consumer.
interface prng_stream_if #(
  parameter int STATE_W = 32,
  parameter int OUT_W   = 8,
  parameter int LEN_W   = 16
);

  logic [STATE_W-1:0] i_seed;
  logic               i_seed_load;
  logic               i_req;
  logic [LEN_W-1:0]   i_req_len;
  logic               i_ready;
  logic [OUT_W-1:0]   o_data;
  logic               o_valid;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_seed, i_seed_load, i_req, i_req_len, i_ready,
    input  o_data, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_seed, i_seed_load, i_req, i_req_len, i_ready,
    output o_data, o_valid, o_busy, o_done
  );

endinterface

// File: rtl/prng_stream.sv
// Xorshift PRNG (32- or 64-bit state) with seed loading, zero-seed guard and a
// burst engine that streams a requested number of words over valid/ready.
module prng_stream #(
  parameter int                 STATE_W      = 32,
  parameter int                 OUT_W        = 8,
  parameter int                 LEN_W        = 16,
  parameter logic [STATE_W-1:0] DEFAULT_SEED = STATE_W'(32'h2545F491)
) (
  input logic          i_clk,
  input logic          i_reset_n,
  prng_stream_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Elaboration-time guards: only the two published xorshift variants exist.
  if (!(STATE_W == 32 || STATE_W == 64)) begin : gBadStateW
    $error("prng_stream: STATE_W must be 32 or 64");
  end
  if (OUT_W < 1 || OUT_W > STATE_W) begin : gBadOutW
    $error("prng_stream: OUT_W must be in 1..STATE_W");
  end
  if (DEFAULT_SEED == '0) begin : gBadSeed
    $error("prng_stream: DEFAULT_SEED must be nonzero");
  end

  logic [1:0]         fsmState_q,   fsmState_d;
  logic [STATE_W-1:0] prngState_q,  prngState_d;
  logic [LEN_W-1:0]   burstCount_q, burstCount_d;
  logic [STATE_W-1:0] safeSeed;
  logic               transfer;

  function automatic logic [STATE_W-1:0] xorshiftStep(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] t;
    t = x;
    if (STATE_W == 64) begin
      t = t ^ (t << 13);
      t = t ^ (t >> 7);
      t = t ^ (t << 17);
    end else begin
      t = t ^ (t << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
    end
    return t;
  endfunction

  // A zero state would lock xorshift at zero forever, so substitute the default.
  assign safeSeed = (bus.i_seed == '0) ? DEFAULT_SEED : bus.i_seed;
  assign transfer = (fsmState_q == RUN) && bus.i_ready;

  always_comb begin
    fsmState_d   = fsmState_q;
    prngState_d  = prngState_q;
    burstCount_d = burstCount_q;
    case (fsmState_q)
      IDLE: begin
        if (bus.i_seed_load) begin
          prngState_d = safeSeed;
        end
        if (bus.i_req) begin
          if (bus.i_req_len != '0) begin
            burstCount_d = bus.i_req_len;
            fsmState_d   = RUN;
          end else begin
            fsmState_d   = DONE;
          end
        end
      end
      RUN: begin
        // State and count only move on an accepted word, keeping o_data stable while stalled.
        if (transfer) begin
          prngState_d  = xorshiftStep(prngState_q);
          burstCount_d = burstCount_q - LEN_W'(1);
          if (burstCount_q == LEN_W'(1)) begin
            fsmState_d = DONE;
          end
        end
      end
      DONE: begin
        fsmState_d = IDLE;
      end
      default: begin
        fsmState_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fsmState_q   <= IDLE;
      prngState_q  <= DEFAULT_SEED;
      burstCount_q <= '0;
    end else begin
      fsmState_q   <= fsmState_d;
      prngState_q  <= prngState_d;
      burstCount_q <= burstCount_d;
    end
  end

  assign bus.o_data  = prngState_q[OUT_W-1:0];
  assign bus.o_valid = (fsmState_q == RUN);
  assign bus.o_busy  = (fsmState_q == RUN) || (fsmState_q == DONE);
  assign bus.o_done  = (fsmState_q == DONE);

  holdWhileStalled: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (bus.o_valid && !bus.i_ready) |=> (bus.o_valid && $stable(bus.o_data)));

endmodule
